backdoor_mem_bridge: RTL and testbench
======================================

Name: backdoor_mem_bridge

Overview:
- Synthesizable bridge between the CoSim system thread's backdoor requests (WRITE32_64/READ32_64 path) and the physical memory ports.
- Converts one 64-bit request into either a granted scratchpad (main memory) port transaction or eight little-endian SD-flash byte accesses.
- Returns exactly one response per accepted request.
- Replaces force/release port hijacking, so no request ever races the functional bus.

Parameters:
- MEM_AW, 16: scratchpad word-address width (64-bit words).
- GRANT_TIMEOUT, 255: maximum cycles to wait for mem_grant before returning an error; valid range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request valid
- req_ready  out  1  bridge can accept a request
- req_write  in  1  1 = write, 0 = read
- req_target  in  1  0 = main memory, 1 = SD flash
- req_addr  in  32  byte address
- req_wdata  in  64  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  64  read data (0 for writes)
- rsp_err  out  1  request failed
- mem_sel  out  1  request/override of the scratchpad port
- mem_grant  in  1  arbiter grant of the scratchpad port
- mem_write  out  1  scratchpad write strobe
- mem_mask  out  8  byte mask; always 8'hFF when mem_write is high
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  64  write data
- mem_rdata  in  64  registered read data, 1-cycle latency
- fl_we  out  1  flash byte write strobe
- fl_addr  out  32  flash byte address
- fl_wdata  out  8  flash write byte
- fl_rdata  in  8  flash read byte, combinational from fl_addr

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous, active-high. On rst, state = IDLE and every output is 0 except req_ready = 1. An in-flight transaction is dropped with no response.
- States and transitions:
  - IDLE: req_ready = 1. On req_valid & req_ready (cycle T), latch the request and go to CHECK.
  - CHECK (T+1): a main-memory request with req_addr[2:0] != 0, or with req_addr[31:3] >= 2^MEM_AW, sets err and goes to RESP. A flash request goes to FL_BYTE. Otherwise go to MEM_REQ.
  - MEM_REQ: mem_sel = 1; the timeout counter increments each cycle. If mem_grant is sampled high, go to MEM_WR (write) or MEM_RD_ADDR (read). If the counter reaches GRANT_TIMEOUT, set err and go to RESP.
  - MEM_WR: one cycle with mem_write = 1, mem_mask = 8'hFF, mem_addr = addr[MEM_AW+2:3], mem_wdata = latched data. Then RESP.
  - MEM_RD_ADDR: one cycle driving mem_addr with mem_write = 0.
  - MEM_RD_DATA: capture mem_rdata into rsp_rdata, then RESP.
  - mem_sel is high from MEM_REQ through MEM_RD_DATA and low in every other state.
  - FL_BYTE: a 3-bit counter i runs 0..7, one byte per cycle, with fl_addr = addr + i (32-bit wrap).
    - Write: fl_we = 1, fl_wdata = data[8i+7:8i].
    - Read: rsp_rdata[8i+7:8i] <= fl_rdata.
    - After i = 7, go to RESP.
  - RESP: rsp_valid = 1, held stable until rsp_ready. On rsp_ready, return to IDLE; req_ready rises the following cycle (no back-to-back bypass).
- Latency from the accept cycle T, with grant already high: main write rsp_valid at T+4; main read at T+5; flash at T+10; error at T+2.
- Grant handling: a grant dropped mid-transaction is ignored once past MEM_REQ. mem_grant is sampled only in MEM_REQ.
- rsp_rdata is 0 for writes and for errors.
- The timeout counter clears on every entry to MEM_REQ.

Decomposition:
- backdoor_pkg holds:
  - state_t enum (IDLE, CHECK, MEM_REQ, MEM_WR, MEM_RD_ADDR, MEM_RD_DATA, FL_BYTE, RESP)
  - target_t enum (TGT_MAIN = 0, TGT_SDFLASH = 1)
  - localparam BYTES_PER_WORD = 8
- One sub-module, bdoor_byte_serializer, owns the i counter, the fl_* drive and read-byte assembly. It has a start/done handshake with the parent FSM.

Test Plan:
- Main write with grant tied high: addr 0x0000_0040, wdata 0xDEAD_BEEF_0123_4567 -> one mem_write pulse with mem_addr = 0x0008 and mask 0xFF; rsp_valid at T+4, rsp_err = 0.
- Main read back of the same address (model returns the stored word 1 cycle later) -> rsp_rdata = 0xDEAD_BEEF_0123_4567 at T+5.
- Misaligned main access addr 0x0000_0044 -> rsp_err = 1 at T+2, mem_sel never asserted.
- mem_grant held low with GRANT_TIMEOUT = 4 -> mem_sel high for 4 cycles, then rsp_err = 1 and mem_sel = 0.
- Flash write addr 0x200, data 0x1122_3344_5566_7788 -> eight fl_we pulses, bytes 0x88, 0x77 … 0x11 at 0x200..0x207. Flash read returns the same 64-bit value.
- rst asserted during MEM_REQ, with rsp_ready held low across the next accepted request -> all outputs 0 immediately, req_ready = 1, no stale response. The following request completes normally, with rsp_valid held until rsp_ready.

Source files
------------

// File: rtl/backdoor_pkg.sv
// Shared types and helpers for the backdoor memory bridge.
package backdoor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MEM_REQ,
    MEM_WR,
    MEM_RD_ADDR,
    MEM_RD_DATA,
    FL_BYTE,
    RESP
  } state_t;

  typedef enum logic {
    TGT_MAIN    = 1'b0,
    TGT_SDFLASH = 1'b1
  } target_t;

  localparam int BYTES_PER_WORD = 8;

  // A main-memory byte address must be word aligned and index an existing word.
  function automatic logic main_addr_bad(input logic [31:0] addr, input int aw);
    logic [31:0] word_hi;
    word_hi = addr >> (aw + 3);
    return (addr[2:0] != 3'd0) || (word_hi != 32'd0);
  endfunction

endpackage

// File: rtl/bdoor_byte_serializer.sv
// Walks one 64-bit request across eight little-endian flash byte accesses.
module bdoor_byte_serializer
  import backdoor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        write,
  input  logic [31:0] base_addr,
  input  logic [63:0] wdata,
  input  logic [7:0]  fl_rdata,
  output logic        done,
  output logic        fl_we,
  output logic [31:0] fl_addr,
  output logic [7:0]  fl_wdata,
  output logic [63:0] rd_word
);

  logic       busy;
  logic [2:0] idx;
  logic       last;

  assign last = (idx == 3'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      idx  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      idx  <= '0;
    end else if (busy) begin
      busy <= !last;
      idx  <= idx + 3'd1;
    end
  end

  // Read bytes land in place; the word is cleared at start so writes report zero.
  always_ff @(posedge clk) begin
    if (start)
      rd_word <= '0;
    else if (busy && !write)
      rd_word[{idx, 3'b000} +: 8] <= fl_rdata;
  end

  assign done     = busy && last;
  assign fl_we    = busy && write;
  assign fl_addr  = busy ? (base_addr + {29'd0, idx}) : '0;
  assign fl_wdata = fl_we ? wdata[{idx, 3'b000} +: 8] : '0;

endmodule

// File: rtl/backdoor_mem_bridge.sv
// Turns one 64-bit backdoor request into a granted scratchpad access or
// eight flash byte accesses, returning exactly one response per request.
module backdoor_mem_bridge
  import backdoor_pkg::*;
#(
  parameter int MEM_AW        = 16,
  parameter int GRANT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_target,
  input  logic [31:0]       req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_sel,
  input  logic              mem_grant,
  output logic              mem_write,
  output logic [7:0]        mem_mask,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              fl_we,
  output logic [31:0]       fl_addr,
  output logic [7:0]        fl_wdata,
  input  logic [7:0]        fl_rdata
);

  state_t      state, next_state;
  logic        write_q;
  target_t     target_q;
  logic [31:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] mem_word;
  logic        err_q;
  logic [15:0] grant_cnt;
  logic        accept, addr_bad, grant_expired;
  logic        ser_start, ser_done;
  logic [63:0] ser_word;

  assign accept        = (state == IDLE) && req_valid;
  assign addr_bad      = (target_q == TGT_MAIN) && main_addr_bad(addr_q, MEM_AW);
  assign grant_expired = (grant_cnt == 16'(GRANT_TIMEOUT - 1));

  always_comb begin
    next_state = state;
    ser_start  = 1'b0;
    unique case (state)
      IDLE:        if (req_valid) next_state = CHECK;
      CHECK: begin
        if (addr_bad)
          next_state = RESP;
        else if (target_q == TGT_SDFLASH) begin
          next_state = FL_BYTE;
          ser_start  = 1'b1;
        end else
          next_state = MEM_REQ;
      end
      MEM_REQ: begin
        if (mem_grant)
          next_state = write_q ? MEM_WR : MEM_RD_ADDR;
        else if (grant_expired)
          next_state = RESP;
      end
      MEM_WR:      next_state = RESP;
      MEM_RD_ADDR: next_state = MEM_RD_DATA;
      MEM_RD_DATA: next_state = RESP;
      FL_BYTE:     if (ser_done) next_state = RESP;
      RESP:        if (rsp_ready) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      target_q  <= TGT_MAIN;
      err_q     <= 1'b0;
      grant_cnt <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        write_q  <= req_write;
        target_q <= target_t'(req_target);
        err_q    <= 1'b0;
      end
      if ((state == CHECK && addr_bad) ||
          (state == MEM_REQ && !mem_grant && grant_expired))
        err_q <= 1'b1;
      // The wait count restarts on every entry to MEM_REQ (always from CHECK).
      if (state == CHECK)
        grant_cnt <= '0;
      else if (state == MEM_REQ)
        grant_cnt <= grant_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      mem_word <= '0;
    end else if (state == MEM_RD_DATA) begin
      mem_word <= mem_rdata;
    end
  end

  bdoor_byte_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .start     (ser_start),
    .write     (write_q),
    .base_addr (addr_q),
    .wdata     (wdata_q),
    .fl_rdata  (fl_rdata),
    .done      (ser_done),
    .fl_we     (fl_we),
    .fl_addr   (fl_addr),
    .fl_wdata  (fl_wdata),
    .rd_word   (ser_word)
  );

  // Outputs are decoded from state so a reset silences every port at once.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = (state != RESP) ? '0 :
                     (target_q == TGT_SDFLASH) ? ser_word : mem_word;
  assign mem_sel   = (state == MEM_REQ) || (state == MEM_WR) ||
                     (state == MEM_RD_ADDR) || (state == MEM_RD_DATA);
  assign mem_write = (state == MEM_WR);
  assign mem_mask  = (state == MEM_WR) ? 8'hFF : 8'h00;
  assign mem_addr  = ((state == MEM_WR) || (state == MEM_RD_ADDR)) ? addr_q[MEM_AW+2:3] : '0;
  assign mem_wdata = (state == MEM_WR) ? wdata_q : '0;

endmodule

// File: tb/tb_backdoor_mem_bridge.sv
// Scoreboard bench for backdoor_mem_bridge with scratchpad and flash models.
module tb_backdoor_mem_bridge;

  localparam int MEM_AW        = 16;
  localparam int GRANT_TIMEOUT = 4;

  logic              clk, rst;
  logic              req_valid, req_ready, req_write, req_target;
  logic [31:0]       req_addr;
  logic [63:0]       req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [63:0]       rsp_rdata;
  logic              mem_sel, mem_grant, mem_write;
  logic [7:0]        mem_mask;
  logic [MEM_AW-1:0] mem_addr;
  logic [63:0]       mem_wdata, mem_rdata;
  logic              fl_we;
  logic [31:0]       fl_addr;
  logic [7:0]        fl_wdata, fl_rdata;

  backdoor_mem_bridge #(.MEM_AW(MEM_AW), .GRANT_TIMEOUT(GRANT_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_target(req_target), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_sel(mem_sel), .mem_grant(mem_grant), .mem_write(mem_write), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fl_we(fl_we), .fl_addr(fl_addr), .fl_wdata(fl_wdata), .fl_rdata(fl_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scratchpad (registered read) and flash (combinational read) models.
  logic [63:0] mem_store [0:255];
  logic [7:0]  fl_mem    [0:4095];
  initial begin
    for (int i = 0; i < 256; i++) mem_store[i] = '0;
    for (int i = 0; i < 4096; i++) fl_mem[i] = '0;
  end
  always @(posedge clk) begin
    if (mem_sel && mem_write) mem_store[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem_store[mem_addr[7:0]];
    if (fl_we) fl_mem[fl_addr[11:0]] <= fl_wdata;
  end
  assign fl_rdata = fl_mem[fl_addr[11:0]];

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;
  exp_t sb[$];

  // Bus activity log, cleared at each request accept.
  int          wr_pulses, sel_cycles;
  logic [15:0] last_maddr;
  logic [7:0]  last_mask;
  logic [39:0] fl_log[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write) begin
        wr_pulses++;
        last_maddr = mem_addr;
        last_mask  = mem_mask;
      end
      if (mem_sel) sel_cycles++;
      if (fl_we) fl_log.push_back({fl_addr, fl_wdata});
    end
  end

  // Response monitor: compares each new response, then checks it holds steady.
  logic        seen = 1'b0;
  logic [63:0] held_rdata;
  logic        held_err;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (rst || !rsp_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
        chk({mon_e.name, "_err"}, 64'(rsp_err), 64'(mon_e.err));
        chk({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc), 64'(mon_e.lat));
      end
      seen       = 1'b1;
      held_rdata = rsp_rdata;
      held_err   = rsp_err;
    end else begin
      chk("rsp_hold_rdata", rsp_rdata, held_rdata);
      chk("rsp_hold_err", 64'(rsp_err), 64'(held_err));
    end
  end

  task automatic issue(input logic wr, input logic tgt, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err,
                       input int lat, input string name, input bit expect_rsp);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({name, "_req_ready_timeout"}, 64'd0, 64'd1);
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_target = tgt;
    req_addr   = addr;
    req_wdata  = wd;
    wr_pulses  = 0;
    sel_cycles = 0;
    fl_log.delete();
    if (expect_rsp) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.lat   = lat;
      e.acc   = cyc;
      e.name  = name;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completion_timeout"}, 64'(sb.size() != 0 || rsp_valid), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0] fdata;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_target = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1; mem_grant = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_ctrl_outs", {rsp_valid, rsp_err, mem_sel, mem_write, fl_we, mem_mask}, 64'd0);
    chk("reset_rsp_rdata", rsp_rdata, 64'd0);
    chk("reset_mem_buses", {mem_addr, fl_wdata, fl_addr}, 64'd0);
    chk("reset_mem_wdata", mem_wdata, 64'd0);
    rst = 1'b0;

    issue(1'b1, 1'b0, 32'h0000_0040, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 4, "main_wr", 1'b1);
    wait_done("main_wr");
    chk("main_wr_pulses", 64'(wr_pulses), 64'd1);
    chk("main_wr_addr", 64'(last_maddr), 64'h0008);
    chk("main_wr_mask", 64'(last_mask), 64'hFF);
    chk("main_wr_sel_cycles", 64'(sel_cycles), 64'd2);

    issue(1'b0, 1'b0, 32'h0000_0040, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0, 5, "main_rd", 1'b1);
    wait_done("main_rd");
    chk("main_rd_pulses", 64'(wr_pulses), 64'd0);
    chk("main_rd_sel_cycles", 64'(sel_cycles), 64'd3);

    issue(1'b1, 1'b0, 32'h0000_0044, 64'h1234, 64'd0, 1'b1, 2, "misaligned", 1'b1);
    wait_done("misaligned");
    chk("misaligned_sel_cycles", 64'(sel_cycles), 64'd0);
    chk("misaligned_pulses", 64'(wr_pulses), 64'd0);

    issue(1'b0, 1'b0, 32'h0008_0000, 64'd0, 64'd0, 1'b1, 2, "out_of_range", 1'b1);
    wait_done("out_of_range");
    chk("out_of_range_sel_cycles", 64'(sel_cycles), 64'd0);

    mem_grant = 1'b0;
    issue(1'b0, 1'b0, 32'h0000_0040, 64'd0, 64'd0, 1'b1, 6, "grant_timeout", 1'b1);
    wait_done("grant_timeout");
    chk("grant_timeout_sel_cycles", 64'(sel_cycles), 64'd4);
    chk("grant_timeout_sel_low", 64'(mem_sel), 64'd0);
    mem_grant = 1'b1;

    fdata = 64'h1122_3344_5566_7788;
    issue(1'b1, 1'b1, 32'h0000_0200, fdata, 64'd0, 1'b0, 10, "flash_wr", 1'b1);
    wait_done("flash_wr");
    chk("flash_wr_count", 64'(fl_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < fl_log.size(); k++)
      chk($sformatf("flash_wr_byte%0d", k), 64'(fl_log[k]),
          64'({32'(32'h200 + k), fdata[8*k +: 8]}));

    issue(1'b0, 1'b1, 32'h0000_0200, 64'd0, fdata, 1'b0, 10, "flash_rd", 1'b1);
    wait_done("flash_rd");
    chk("flash_rd_no_writes", 64'(fl_log.size()), 64'd0);

    // Abort a request stuck in MEM_REQ, then run one with a stalled consumer.
    mem_grant = 1'b0;
    issue(1'b1, 1'b0, 32'h0000_0048, 64'hBAD0_BAD0_BAD0_BAD0, 64'd0, 1'b0, 0, "aborted", 1'b0);
    @(negedge clk);
    chk("abort_in_mem_req", 64'(mem_sel), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_ctrl_outs", {rsp_valid, rsp_err, mem_sel, mem_write, fl_we, mem_mask}, 64'd0);
    chk("abort_mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_grant = 1'b1;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_stale_rsp", 64'(rsp_valid), 64'd0);

    issue(1'b1, 1'b0, 32'h0000_0048, 64'hCAFE_F00D_55AA_1234, 64'd0, 1'b0, 4, "held_wr", 1'b1);
    repeat (8) @(negedge clk);
    chk("held_wr_valid_held", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    wait_done("held_wr");
    chk("held_wr_pulses", 64'(wr_pulses), 64'd1);
    chk("held_wr_addr", 64'(last_maddr), 64'h0009);

    issue(1'b0, 1'b0, 32'h0000_0048, 64'd0, 64'hCAFE_F00D_55AA_1234, 1'b0, 5, "held_rd", 1'b1);
    wait_done("held_rd");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
